ahb_to_apb_ms_bridge: RTL and testbench

AHB_TO_APB_MS_BRIDGE -- requirements
Module: ahb_to_apb_ms_bridge

---
 rtl/ahb_to_apb_ms_bridge_pkg.sv | 37 +++
 rtl/ahb_to_apb_ms_bridge_apb_slv_mux.sv | 30 +++
 rtl/ahb_to_apb_ms_bridge.sv | 170 +++++++++++++++++
 tb/tb_ahb_to_apb_ms_bridge.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ahb_to_apb_ms_bridge_pkg.sv
// Shared state encoding, AHB transfer-type constants and helpers for the AHB-to-APB bridge.
package ahb_to_apb_ms_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ENDOK  = 3'd4,
    ST_ERR1   = 3'd5,
    ST_ERR2   = 3'd6
  } bridge_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) r++;
    return r;
  endfunction

  // Write byte lanes for a 32-bit bus; sizes above a word still enable all lanes.
  function automatic logic [3:0] wr_strobe(input logic [2:0] size, input logic [1:0] lane);
    logic [3:0] s;
    case (size)
      3'd0:    s = 4'b0001 << lane;
      3'd1:    s = lane[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ahb_to_apb_ms_bridge_apb_slv_mux.sv
// Picks read data, ready and error of the addressed APB slave; all other slaves are ignored.
module apb_slv_mux
  import ahb_to_apb_ms_bridge_pkg::*;
#(
  parameter int NSLV = 4,
  parameter int IW   = 2
) (
  input  logic [IW-1:0]      idx_i,
  input  logic [32*NSLV-1:0] prdata_i,
  input  logic [NSLV-1:0]    pready_i,
  input  logic [NSLV-1:0]    pslverr_i,
  output logic [31:0]        prdata_o,
  output logic               pready_o,
  output logic               pslverr_o
);

  always_comb begin
    prdata_o  = '0;
    pready_o  = 1'b0;
    pslverr_o = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (int'(idx_i) == i) begin
        prdata_o  = prdata_i[32*i +: 32];
        pready_o  = pready_i[i];
        pslverr_o = pslverr_i[i];
      end
    end
  end

endmodule

// File: rtl/ahb_to_apb_ms_bridge.sv
// AHB-Lite to APB bridge: one-hot slave decode, APB phases aligned to PCLKEN,
// two-cycle AHB error on decode miss, slave error or optional wait-state timeout.
module ahb_to_apb_ms_bridge
  import ahb_to_apb_ms_bridge_pkg::*;
#(
  parameter int ADDRWIDTH = 16,
  parameter int NSLV      = 4,
  parameter int SLVBITS   = 12,
  parameter int TIMEOUT   = 0
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 PCLKEN,
  input  logic                 HSEL,
  input  logic                 HWRITE,
  input  logic                 HREADY,
  input  logic [ADDRWIDTH-1:0] HADDR,
  input  logic [1:0]           HTRANS,
  input  logic [2:0]           HSIZE,
  input  logic [3:0]           HPROT,
  input  logic [31:0]          HWDATA,
  output logic                 HREADYOUT,
  output logic                 HRESP,
  output logic [31:0]          HRDATA,
  output logic [ADDRWIDTH-1:0] PADDR,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [3:0]           PSTRB,
  output logic [2:0]           PPROT,
  output logic [31:0]          PWDATA,
  output logic [NSLV-1:0]      PSEL,
  input  logic [32*NSLV-1:0]   PRDATA,
  input  logic [NSLV-1:0]      PREADY,
  input  logic [NSLV-1:0]      PSLVERR,
  output logic                 APBACTIVE
);

  localparam int IDXBITS = clog2(NSLV);
  localparam int IW      = (IDXBITS == 0) ? 1 : IDXBITS;
  localparam int CW      = (clog2(TIMEOUT + 1) == 0) ? 1 : clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  bridge_state_e        state_q, state_d;
  logic [ADDRWIDTH-3:0] addr_q;
  logic                 write_q;
  logic [2:0]           prot_q;
  logic [3:0]           strb_q;
  logic [IW-1:0]        idx_q;
  logic [31:0]          rdata_q;
  logic [CW-1:0]        cnt_q;

  logic          apb_select, accept, idx_miss, timeout_hit;
  logic [IW-1:0] idx_in;
  logic [31:0]   sel_prdata;
  logic          sel_pready, sel_pslverr;
  logic          unused_hprot;

  assign unused_hprot = ^HPROT[3:2];
  assign apb_select   = HSEL & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ)) & HREADY;
  assign accept       = (state_q == ST_IDLE) | (state_q == ST_ENDOK) | (state_q == ST_ERR2);

  generate
    if (IDXBITS == 0) begin : g_one_slv
      assign idx_in = '0;
    end else begin : g_idx
      assign idx_in = HADDR[SLVBITS +: IW];
    end
  endgenerate

  assign idx_miss = (int'(idx_in) >= NSLV);

  apb_slv_mux #(.NSLV(NSLV), .IW(IW)) u_slv_mux (
    .idx_i     (idx_q),
    .prdata_i  (PRDATA),
    .pready_i  (PREADY),
    .pslverr_i (PSLVERR),
    .prdata_o  (sel_prdata),
    .pready_o  (sel_pready),
    .pslverr_o (sel_pslverr)
  );

  // Fires on the TIMEOUT-th not-ready PCLKEN edge of the access phase.
  always_comb begin
    timeout_hit = 1'b0;
    if (TIMEOUT > 0)
      timeout_hit = (state_q == ST_ACCESS) & PCLKEN & ~sel_pready & (cnt_q == CNT_LAST);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ENDOK, ST_ERR2: begin
        if (!apb_select)   state_d = ST_IDLE;
        else if (idx_miss) state_d = ST_ERR1;
        else if (PCLKEN)   state_d = ST_SETUP;
        else               state_d = ST_WAIT;
      end
      ST_WAIT:  if (PCLKEN) state_d = ST_SETUP;
      ST_SETUP: if (PCLKEN) state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (PCLKEN && sel_pready) state_d = sel_pslverr ? ST_ERR1 : ST_ENDOK;
        else if (timeout_hit)     state_d = ST_ERR1;
      end
      ST_ERR1:  state_d = ST_ERR2;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b0;
    HRESP     = 1'b0;
    PENABLE   = 1'b0;
    PSEL      = '0;
    case (state_q)
      ST_IDLE, ST_ENDOK: HREADYOUT = 1'b1;
      ST_ERR1:           HRESP = 1'b1;
      ST_ERR2: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b1;
      end
      ST_ACCESS:         PENABLE = 1'b1;
      default: ;
    endcase
    for (int i = 0; i < NSLV; i++)
      PSEL[i] = ((state_q == ST_SETUP) | (state_q == ST_ACCESS)) & (int'(idx_q) == i);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      prot_q  <= '0;
      strb_q  <= '0;
      idx_q   <= '0;
    end else if (apb_select && accept) begin
      addr_q  <= HADDR[ADDRWIDTH-1:2];
      write_q <= HWRITE;
      prot_q  <= {~HPROT[0], 1'b0, HPROT[1]};
      strb_q  <= HWRITE ? wr_strobe(HSIZE, HADDR[1:0]) : 4'b0000;
      idx_q   <= idx_in;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (state_q == ST_ACCESS && state_d == ST_ENDOK) rdata_q <= sel_prdata;
      if (state_q != ST_ACCESS)
        cnt_q <= '0;
      else if (PCLKEN && !sel_pready && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign HRDATA    = rdata_q;
  assign PADDR     = {addr_q, 2'b00};
  assign PWRITE    = write_q;
  assign PSTRB     = strb_q;
  assign PPROT     = prot_q;
  assign PWDATA    = HWDATA;
  assign APBACTIVE = (HSEL & HTRANS[1]) | (state_q != ST_IDLE);

endmodule

// File: tb/tb_ahb_to_apb_ms_bridge.sv
// Randomized bench for the AHB-to-APB bridge: a reactive APB slave plus a transfer-level
// timing model derived from the PCLKEN edges available to each transfer.
`timescale 1ns/1ps
module tb_ahb_to_apb_ms_bridge;
  localparam int AW = 16, NS = 3, SB = 12, TO = 4;

  logic HCLK = 1'b0;
  logic HRESETn, PCLKEN, HSEL, HWRITE, HREADY;
  logic [AW-1:0] HADDR;
  logic [1:0] HTRANS;
  logic [2:0] HSIZE;
  logic [3:0] HPROT;
  logic [31:0] HWDATA;
  logic HREADYOUT, HRESP;
  logic [31:0] HRDATA;
  logic [AW-1:0] PADDR;
  logic PENABLE, PWRITE;
  logic [3:0] PSTRB;
  logic [2:0] PPROT;
  logic [31:0] PWDATA;
  logic [NS-1:0] PSEL;
  logic [32*NS-1:0] PRDATA;
  logic [NS-1:0] PREADY, PSLVERR;
  logic APBACTIVE;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_rdata;

  always #5 HCLK = ~HCLK;

  ahb_to_apb_ms_bridge #(.ADDRWIDTH(AW), .NSLV(NS), .SLVBITS(SB), .TIMEOUT(TO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PCLKEN(PCLKEN), .HSEL(HSEL), .HWRITE(HWRITE),
    .HREADY(HREADY), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HPROT(HPROT),
    .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .PADDR(PADDR),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PSTRB(PSTRB), .PPROT(PPROT), .PWDATA(PWDATA),
    .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .APBACTIVE(APBACTIVE)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input logic exp_active);
    chk_eq("rst_hreadyout", 32'(HREADYOUT), 32'(1));
    chk_eq("rst_hresp", 32'(HRESP), 32'(0));
    chk_eq("rst_psel", 32'(PSEL), 32'(0));
    chk_eq("rst_penable", 32'(PENABLE), 32'(0));
    chk_eq("rst_paddr", 32'(PADDR), 32'(0));
    chk_eq("rst_pstrb", 32'(PSTRB), 32'(0));
    chk_eq("rst_pwrite", 32'(PWRITE), 32'(0));
    chk_eq("rst_pprot", 32'(PPROT), 32'(0));
    chk_eq("rst_hrdata", HRDATA, 32'(0));
    chk_eq("rst_apbactive", 32'(APBACTIVE), 32'(exp_active));
  endtask

  // Drives PCLKEN and all slaves for the coming edge; unaddressed slaves get random noise.
  task automatic drive_edge(input bit pclk, input int tgt, input int waits, input logic serr,
                            input logic [31:0] rdata, inout int nr);
    logic ready;
    PCLKEN = pclk;
    for (int i = 0; i < NS; i++) begin
      PREADY[i]  = 1'($urandom_range(0, 1));
      PSLVERR[i] = 1'($urandom_range(0, 1));
      PRDATA[32*i +: 32] = $urandom();
    end
    if (tgt < NS) begin
      ready = (nr >= waits);
      PREADY[tgt]  = ready;
      PSLVERR[tgt] = serr;
      PRDATA[32*tgt +: 32] = rdata;
      if (PENABLE && pclk && !ready) nr++;
    end
  endtask

  task automatic do_xfer(input logic [AW-1:0] addr, input logic wr, input logic [2:0] size,
                         input logic [3:0] prot, input logic [31:0] wdata, input logic [31:0] rdata,
                         input int waits, input logic serr, input int pmode, input int rst_at);
    bit arr[64];
    int pk[$];
    int tgt, c, busy_end, nr, nbytes, lane;
    bit miss, err, in_sel, in_en;
    logic [3:0] strb_exp;
    logic [NS-1:0] sel_exp;
    for (int j = 0; j < 64; j++) begin
      case (pmode)
        0:       arr[j] = 1'b1;
        1:       arr[j] = (j % 2 == 1);
        default: arr[j] = ($urandom_range(0, 1) == 1) || (j % 8 == 7);
      endcase
      if (arr[j]) pk.push_back(j);
    end
    tgt      = int'(addr[SB +: 2]);
    miss     = (tgt >= NS);
    err      = miss || (waits >= TO) || serr;
    c        = miss ? 0 : pk[2 + ((waits < TO - 1) ? waits : TO - 1)];
    busy_end = err ? c + 1 : c;
    nbytes   = 1 << size;
    lane     = int'(addr[1:0]) & ~(nbytes - 1);
    strb_exp = wr ? 4'(((1 << nbytes) - 1) << lane) : 4'h0;
    sel_exp  = miss ? '0 : NS'(1 << tgt);

    HSEL = 1'b1; HTRANS = 2'b10; HREADY = 1'b1; HADDR = addr; HWRITE = wr;
    HSIZE = size; HPROT = prot; HWDATA = wdata;
    nr = 0;
    drive_edge(arr[0], tgt, waits, serr, rdata, nr);
    for (int j = 0; j <= busy_end + 1; j++) begin
      @(negedge HCLK);
      in_sel = !miss && (j >= pk[0]) && (j < c);
      in_en  = !miss && (j >= pk[1]) && (j < c);
      if (!err && j == c) last_rdata = rdata;
      chk_eq("hreadyout", 32'(HREADYOUT), 32'(j >= busy_end));
      chk_eq("hresp", 32'(HRESP), 32'(err && (j == c || j == c + 1)));
      chk_eq("psel", 32'(PSEL), 32'(in_sel ? sel_exp : '0));
      chk_eq("penable", 32'(PENABLE), 32'(in_en));
      chk_eq("apbactive", 32'(APBACTIVE), 32'((j <= busy_end) || (HSEL && HTRANS[1])));
      chk_eq("paddr", 32'(PADDR), 32'({addr[AW-1:2], 2'b00}));
      chk_eq("pstrb", 32'(PSTRB), 32'(strb_exp));
      chk_eq("pwrite", 32'(PWRITE), 32'(wr));
      chk_eq("pprot", 32'(PPROT), 32'({~prot[0], 1'b0, prot[1]}));
      chk_eq("pwdata", PWDATA, wdata);
      chk_eq("hrdata", HRDATA, last_rdata);
      if (j == 0) begin
        HSEL = 1'b0; HTRANS = 2'b00; HADDR = AW'($urandom());
      end
      if (j == rst_at) begin
        HRESETn = 1'b0;
        #1;
        last_rdata = '0;
        chk_reset_outputs(1'b0);
        @(negedge HCLK);
        chk_eq("rst_hold_psel", 32'(PSEL), 32'(0));
        HRESETn = 1'b1;
        return;
      end
      drive_edge(arr[j + 1], tgt, waits, serr, rdata, nr);
    end
  endtask

  initial begin
    HRESETn = 1'b0; PCLKEN = 1'b0; HSEL = 1'b0; HWRITE = 1'b0; HREADY = 1'b1;
    HADDR = '0; HTRANS = 2'b00; HSIZE = 3'd0; HPROT = 4'h0; HWDATA = '0;
    PRDATA = '0; PREADY = '0; PSLVERR = '0;
    last_rdata = '0;
    repeat (3) @(negedge HCLK);
    chk_reset_outputs(1'b0);
    HSEL = 1'b1; HTRANS = 2'b10;
    #1;
    chk_eq("rst_apbactive_hsel", 32'(APBACTIVE), 32'(1));
    HSEL = 1'b0; HTRANS = 2'b00;
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);

    do_xfer(16'h1004, 1'b0, 3'd2, 4'h0, 32'h0, 32'hA5A5_0001, 0, 1'b0, 0, -1);
    do_xfer(16'h2003, 1'b1, 3'd0, 4'h3, 32'h1100_0000, 32'h0, 1, 1'b0, 0, -1);
    do_xfer(16'h3000, 1'b0, 3'd2, 4'h1, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, 0, -1);
    do_xfer(16'h1008, 1'b0, 3'd2, 4'h2, 32'h0, 32'h1234_5678, 8, 1'b0, 0, -1);
    do_xfer(16'h0010, 1'b1, 3'd1, 4'h0, 32'hCAFE_F00D, 32'h0, 1, 1'b1, 1, -1);
    do_xfer(16'h0202, 1'b1, 3'd1, 4'h2, 32'h5555_AAAA, 32'h0, 3, 1'b0, 1, -1);
    do_xfer(16'h1000, 1'b0, 3'd2, 4'h0, 32'h0, 32'h0BAD_0BAD, 10, 1'b0, 0, 2);

    for (int t = 0; t < 160; t++) begin
      do_xfer(AW'($urandom()), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 2)),
              4'($urandom()), $urandom(), $urandom(), int'($urandom_range(0, 5)),
              ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
